// File: rtl/pingpong_buf_stream.sv
// ============================================================================
// Module  : pingpong_buf_stream
// Brief   : Two-bank word buffer with valid/ready on both sides.
//           Banks swap when full or when a flush closes a short block.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pingpong_buf_stream #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [1:0]       bank_full,
    output logic             wr_bank,
    output logic             rd_bank
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [WIDTH-1:0] mem_q [2][DEPTH];

    logic [1:0]    full_q, full_d;
    logic [CW-1:0] len_q [2];
    logic [CW-1:0] len_d [2];
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;

    logic          wr_beat;
    logic          rd_beat;
    logic          bank_close;
    logic          mem_we;
    logic [CW-1:0] wr_cnt_inc;

    assign in_ready   = ~full_q[wr_sel_q];
    assign wr_beat    = in_valid & in_ready;
    assign wr_cnt_inc = wr_cnt_q + {{(CW-1){1'b0}}, wr_beat};
    // A flush only closes a bank that will hold at least one word.
    assign bank_close = in_ready &
                        ((wr_beat & (wr_cnt_q == LAST_IDX)) |
                         (in_flush & ((wr_cnt_q != '0) | wr_beat)));
    assign mem_we     = wr_beat & ~clear;

    assign out_valid  = full_q[rd_sel_q];
    assign out_data   = out_valid ? mem_q[rd_sel_q][rd_ptr_q[AW-1:0]] : '0;
    assign out_last   = out_valid & (rd_ptr_q == (len_q[rd_sel_q] - ONE));
    assign rd_beat    = out_valid & out_ready;

    assign bank_full  = full_q;
    assign wr_bank    = wr_sel_q;
    assign rd_bank    = rd_sel_q;

    always_comb begin
        full_d   = full_q;
        len_d[0] = len_q[0];
        len_d[1] = len_q[1];
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_cnt_d = wr_cnt_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            full_d   = 2'b00;
            len_d[0] = '0;
            len_d[1] = '0;
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
            wr_cnt_d = '0;
            rd_ptr_d = '0;
        end else begin
            // Writer and reader always own different banks, so both may update full_d.
            if (bank_close) begin
                full_d[wr_sel_q] = 1'b1;
                len_d[wr_sel_q]  = wr_cnt_inc;
                wr_cnt_d         = '0;
                wr_sel_d         = ~wr_sel_q;
            end else begin
                wr_cnt_d         = wr_cnt_inc;
            end
            if (rd_beat) begin
                if (out_last) begin
                    full_d[rd_sel_q] = 1'b0;
                    rd_ptr_d         = '0;
                    rd_sel_d         = ~rd_sel_q;
                end else begin
                    rd_ptr_d         = rd_ptr_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= 2'b00;
            len_q[0] <= '0;
            len_q[1] <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            full_q   <= full_d;
            len_q[0] <= len_d[0];
            len_q[1] <= len_d[1];
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: out_data is masked until a bank is closed.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_sel_q][wr_cnt_q[AW-1:0]] <= in_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pingpong_buf_stream.sv
// ============================================================================
// Module  : tb_pingpong_buf_stream
// Brief   : Directed self-checking bench for pingpong_buf_stream (WIDTH=8, DEPTH=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pingpong_buf_stream;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [1:0]       bank_full;
    logic             wr_bank;
    logic             rd_bank;

    int n_vec = 0;
    int n_err = 0;

    pingpong_buf_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .bank_full (bank_full),
        .wr_bank   (wr_bank),
        .rd_bank   (rd_bank)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d, input logic flush);
        in_valid = 1'b1;
        in_data  = d;
        in_flush = flush;
        step();
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    initial begin
        int wi;
        int ri;
        int budget;
        logic wbeat;
        logic rbeat;
        logic dropped;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_flush = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_last",  out_last,  0);
        check("rst_bank_full", bank_full, 0);
        check("rst_wr_bank",   wr_bank,   0);
        check("rst_rd_bank",   rd_bank,   0);

        // One-word flushed block, then asynchronous reset mid-cycle
        wr(8'h55, 1'b1);
        check("pre_rst_bank_full", bank_full, 2'b01);
        check("pre_rst_out_data",  out_data,  8'h55);
        check("pre_rst_out_last",  out_last,  1);
        check("pre_rst_wr_bank",   wr_bank,   1);
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_data",  out_data,  0);
        check("async_bank_full", bank_full, 0);
        check("async_wr_bank",   wr_bank,   0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_in_ready",  in_ready,  1);
        check("post_rst_out_valid", out_valid, 0);

        // Full-bank swap
        wr(8'h11, 1'b0); wr(8'h22, 1'b0); wr(8'h33, 1'b0); wr(8'h44, 1'b0);
        check("swap_bank_full", bank_full, 2'b01);
        check("swap_wr_bank",   wr_bank,   1);
        check("swap_in_ready",  in_ready,  1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("swap_data", out_data, 8'h11 * (i + 1));
            check("swap_last", out_last, (i == 3));
            step();
        end
        out_ready = 1'b0;
        check("swap_drained_full", bank_full, 2'b00);
        check("swap_rd_bank",      rd_bank,   1);
        check("swap_drained_vld",  out_valid, 0);

        // Back-pressure: 8 words fill both banks, ninth word waits
        for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i), 1'b0);
        check("bp_in_ready", in_ready,  0);
        check("bp_full",     bank_full, 2'b11);
        in_valid = 1'b1; in_data = 8'h88;
        step(); step();
        check("bp_stall_in_ready", in_ready,  0);
        check("bp_stall_full",     bank_full, 2'b11);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_data_a",     out_data, 8'h80 + i);
            check("bp_last_a",     out_last, (i == 3));
            check("bp_hold_ready", in_ready, 0);
            step();
        end
        check("bp_release_ready", in_ready, 1);
        check("bp_rd_bank",       rd_bank,  0);
        check("bp_data_b0",       out_data, 8'h84);
        step();
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("bp_data_b", out_data, 8'h84 + i);
            check("bp_last_b", out_last, (i == 3));
            step();
        end
        check("bp_ninth_pending", out_valid, 0);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        check("bp_ninth_data", out_data, 8'h88);
        check("bp_ninth_last", out_last, 1);
        step();
        out_ready = 1'b0;
        check("bp_empty_full", bank_full, 2'b00);

        // Concurrent stream 0..31
        wi = 0; ri = 0; budget = 0; dropped = 1'b0;
        out_ready = 1'b1;
        while (ri < 32 && budget < 200) begin
            in_valid = (wi < 32);
            in_data  = 8'(wi);
            if (wi >= 4 && wi < 32 && !in_ready) dropped = 1'b1;
            if (out_valid) begin
                check("stream_data", out_data, ri);
                check("stream_last", out_last, (ri % 4 == 3));
            end
            wbeat = in_valid & in_ready;
            rbeat = out_valid & out_ready;
            step();
            if (wbeat) wi++;
            if (rbeat) ri++;
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_count",   ri,      32);
        check("stream_dropped", dropped, 0);

        // Flush-closed short block
        wr(8'hA0, 1'b0); wr(8'hA1, 1'b0); wr(8'hA2, 1'b1);
        check("flush_full",    bank_full, 2'b01);
        check("flush_wr_bank", wr_bank,   1);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        check("flush_empty_full", bank_full, 2'b01);
        check("flush_empty_wrb",  wr_bank,   1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("flush_data", out_data, 8'hA0 + i);
            check("flush_last", out_last, (i == 2));
            step();
        end
        out_ready = 1'b0;
        check("flush_drained", bank_full, 2'b00);

        // clear with both banks full and reader mid-block
        for (int i = 0; i < 8; i++) wr(8'hC0 + 8'(i), 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("clr_mid_data", out_data, 8'hC1);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        step();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_out_valid", out_valid, 0);
        check("clr_bank_full", bank_full, 2'b00);
        check("clr_wr_bank",   wr_bank,   0);
        check("clr_rd_bank",   rd_bank,   0);
        check("clr_in_ready",  in_ready,  1);
        for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i), 1'b0);
        check("clr_blk_full", bank_full, 2'b01);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("clr_blk_data", out_data, 8'hD0 + i);
            check("clr_blk_last", out_last, (i == 3));
            step();
        end
        out_ready = 1'b0;
        check("clr_blk_drained", bank_full, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pingpong_buf_stream.md
Name: pingpong_buf_stream

Overview:
- Parametrised double-buffered (ping-pong) stream buffer for the FIR datapath.
- Widens the bit-serial ping-pong buffer to WIDTH-bit words and DEPTH-word banks.
- Adds valid/ready handshakes on both sides.
- Bank swap is automatic: on bank-full or on a flush-initiated short block. No external switch strobe.
- Sits between sample source and FIR core so the core drains one block while the next block fills.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 64, words per bank (>=2); pointers/counters are $clog2(DEPTH+1) bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous: discard both banks, return to reset state next cycle
in_valid  input  1  write beat offered
in_ready  output  1  buffer can accept a write beat
in_data  input  WIDTH  write word
in_flush  input  1  close the current write bank after this cycle (qualified, see Behaviour)
out_valid  output  1  read word available
out_ready  input  1  consumer accepts read word
out_data  output  WIDTH  read word
out_last  output  1  out_data is the final word of the current bank
bank_full  output  2  per-bank "closed, awaiting/under drain" flags
wr_bank  output  1  bank index currently being written
rd_bank  output  1  bank index currently being read

Behaviour:
- Storage: mem[2][DEPTH] of WIDTH bits.
- Per-bank state: full[b] and len[b] (words stored).
- Write side: wr_sel, wr_cnt. Read side: rd_sel, rd_ptr.
- Reset (async rst) or clear (sync) sets:
  - wr_sel=0, rd_sel=0, wr_cnt=0, rd_ptr=0, full=2'b00, len=0.
  - in_ready=1, out_valid=0, out_last=0, out_data=0, bank_full=0, wr_bank=0, rd_bank=0.
  - clear has priority over any simultaneous beat; that beat is dropped.
- Write side:
  - in_ready = !full[wr_sel] (combinational).
  - Write beat = in_valid & in_ready: mem[wr_sel][wr_cnt] <= in_data, wr_cnt++.
  - Bank close condition (evaluated each cycle with in_ready=1):
    - (a) write beat with wr_cnt==DEPTH-1, or
    - (b) in_flush=1 and (wr_cnt>0 or a write beat occurs this cycle).
  - On close: full[wr_sel]<=1, len[wr_sel]<=words including this cycle's beat, wr_cnt<=0, wr_sel toggles.
  - in_flush with wr_cnt==0 and no beat: ignored.
  - in_flush while in_ready=0: ignored (not held).
  - Both banks full: in_ready=0, no data loss, upstream stalls.
- Read side:
  - out_valid = full[rd_sel].
  - out_data = mem[rd_sel][rd_ptr] (combinational read of registered storage, zero added latency). Forced 0 when !out_valid.
  - out_last = out_valid & (rd_ptr == len[rd_sel]-1).
  - Read beat = out_valid & out_ready: rd_ptr++.
  - On read beat with out_last: full[rd_sel]<=0, rd_ptr<=0, rd_sel toggles.
  - out_data/out_last held stable while out_valid & !out_ready.
- Latency: the last word written into a bank, closing it at edge N, appears at out_valid at edge N (visible in cycle N+1) if the read side is idle on that bank.
- Simultaneous events:
  - Writer closing bank X and reader releasing bank Y (X!=Y) in the same cycle: both take effect.
  - Reader releasing bank X while writer is stalled on X (both full): in_ready rises the next cycle, not combinationally the same cycle.
  - Writer and reader never operate on the same bank concurrently: the writer only touches !full banks, the reader only touches full banks.
- Ordering: blocks are delivered strictly in close order; words within a block are delivered in write order.
- Reset mid-operation: all stored data discarded, no partial block emitted after deassertion.

Test Plan:
- Reset/idle (WIDTH=8, DEPTH=4): assert rst async mid-cycle -> all outputs 0 immediately, in_ready=1 after release.
- Full-bank swap: write 0x11,0x22,0x33,0x44 with out_ready=0 -> bank_full=01, wr_bank=1. Set out_ready=1 -> read 0x11..0x44, out_last only on 0x44, then bank_full=00, rd_bank=1.
- Back-pressure: write 8 words with out_ready=0 -> in_ready=0 after 8th beat. Ninth word held. Read one full block -> in_ready=1 one cycle after last read beat. No word lost or duplicated.
- Concurrent stream: continuous in_valid=1, out_ready=1, data 0..31 -> output 0..31 in order, out_last every 4th word. in_ready never drops after first fill.
- Flush: write 0xA0,0xA1, then 0xA2 with in_flush=1 -> block len 3, out_last on 0xA2. in_flush with empty wr bank -> no change.
- clear during activity: both banks full, reader mid-block, pulse clear -> next cycle out_valid=0, bank_full=00, wr_bank=rd_bank=0. A subsequent 4-word block reads back correctly.
